// File: rtl/onehot_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : onehot_rr_arbiter_if
// Description : Request/grant bundle between requesters and onehot_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface onehot_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  owner,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output owner,
        output busy,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onehot_rr_arbiter
// Description : 4-way round-robin arbiter with a registered one-hot grant.
//               Define ARB_TIMEOUT_EN to revoke grants held for HOLD_MAX cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    onehot_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] last_q;
    logic       init_q;
    logic [1:0] last_d;
    logic       win_d;
    logic [1:0] cand;
    logic [1:0] owner_dec;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("onehot_rr_arbiter: HOLD_MAX must be within 2..255");
    end

    // Search upward from the slot after the previous owner, wrapping at 3.
    always_comb begin
        win_d  = 1'b0;
        last_d = 2'd0;
        cand   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_d && bus.req[cand]) begin
                win_d  = 1'b1;
                last_d = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;
`endif

    // init_q holds off grants until the second edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 4'b0000;
            last_q    <= 2'd3;
            init_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            init_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (init_q && win_d) begin
                        state_q <= S_GRANT;
                        grant_q <= 4'b0001 << last_d;
                        last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= 8'd1;
`endif
                    end
                end
                S_GRANT: begin
                    if (!bus.req[last_q]) begin
                        state_q <= S_IDLE;
                        grant_q <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= 8'd0;
                    end else if (hold_q == 8'(HOLD_MAX)) begin
                        // Forced revoke; last_q keeps the revoked owner so rotation moves on.
                        state_q   <= S_IDLE;
                        grant_q   <= 4'b0000;
                        hold_q    <= 8'd0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q  <= hold_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        owner_dec = 2'd0;
        case (grant_q)
            4'b0010: owner_dec = 2'd1;
            4'b0100: owner_dec = 2'd2;
            4'b1000: owner_dec = 2'd3;
            default: owner_dec = 2'd0;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.owner = owner_dec;
    assign bus.busy  = |grant_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines, bit i = requester i; level-sensitive.
REQ-005 grant  output  4  registered grant vector; always 4'b0000 or one-hot; drives S of the downstream one-hot detector.
REQ-006 owner  output  2  index of the current grant holder; valid only while busy=1, else 2'd0.
REQ-007 busy  output  1  1 when grant != 0.
REQ-008 timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-009 The FSM SHALL have two states: IDLE (grant=0) and GRANT (exactly one grant bit set).
REQ-010 The IDLE->GRANT transition SHALL occur when req != 0; the grant SHALL appear one cycle after req is sampled (1-cycle latency).
REQ-011 The winner SHALL be the first set req bit searching upward from (last+1) mod 4, wrapping 3->0, where last is the most recent owner.
REQ-012 The pointer last SHALL update to the winner in the same edge that asserts grant.
REQ-013 In GRANT, grant SHALL hold unchanged while req[owner]=1, regardless of the other req bits.
REQ-014 When req[owner]=0 is sampled in GRANT, grant SHALL go to 0 on the next edge (IDLE), giving one mandatory zero-grant cycle before any new grant.
REQ-015 Requests asserted and dropped entirely within a cycle in which the block is in GRANT SHALL NOT be remembered; no request queueing.
REQ-016 The grant vector SHALL never have more than one bit set in any cycle, including reset release.
REQ-017 busy SHALL equal |grant; owner SHALL equal the encoded index of grant; both are combinational decodes of the grant register.
REQ-018 req=4'b1111 held continuously with owners releasing SHALL yield grant order 0,1,2,3,0,... with one zero cycle between each grant.

Reset
REQ-019 While rst=1: grant=4'b0000, owner=2'd0, busy=0, timeout=0, state=IDLE, last=2'd3 (requester 0 has first priority), hold counter=0.
REQ-020 Reset asserted mid-grant SHALL clear grant immediately (asynchronously), without waiting for a clock edge.
REQ-021 The first grant after reset release SHALL occur no earlier than the second rising edge after rst falls.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN SHALL compile in a hold counter that increments each GRANT cycle from 1.
REQ-023 With ARB_TIMEOUT_EN: when the counter reaches HOLD_MAX with req[owner] still 1, the next edge SHALL clear grant, enter IDLE, and pulse timeout=1 for exactly that one cycle; last SHALL remain the revoked owner, so rotation continues past it.
REQ-024 With ARB_TIMEOUT_EN: a voluntary release in the same cycle the counter reaches HOLD_MAX SHALL be treated as normal release, with timeout=0.
REQ-025 Without ARB_TIMEOUT_EN: no counter is present, timeout is tied to 0, and grant is held indefinitely while req[owner]=1.

Verification
REQ-026 Reset release with req=4'b0000 for 5 cycles -> grant=0, busy=0, owner=0 throughout.
REQ-027 req=4'b1010 from reset -> grant=4'b0010 after 1 cycle; drop req[1] -> grant=0 for one cycle, then grant=4'b1000, owner=3.
REQ-028 req=4'b1111 held; bench drops the owner's bit for one cycle after every 3-cycle grant -> grant sequence 0001,0010,0100,1000,0001; grant is never multi-hot, which is checked through the downstream detector (Valid=1 or Zero=1 every cycle).
REQ-029 Grant 4'b0100 active; assert rst between clock edges -> grant=0 before the next edge; after release, last=3 and req=4'b0100 -> grant=4'b0100.
REQ-030 ARB_TIMEOUT_EN, HOLD_MAX=8, req=4'b0011 held -> grant=0001 for 8 cycles, then grant=0 with timeout=1 for one cycle, then grant=0010.
REQ-031 ARB_TIMEOUT_EN undefined, req=4'b0001 held for 300 cycles -> grant=0001 continuously, timeout=0.
